// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N packet stream demultiplexer.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    // Select width for N channels; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register: payload, last flag and destination channel with valid/ready.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          load_last,
    input  logic [SW-1:0] load_sel,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic          reg_valid,
    output logic          can_load
);

    logic [SW-1:0] reg_sel;
    logic          drain;

    assign drain    = reg_valid && out_ready[reg_sel];
    assign can_load = !reg_valid || out_ready[reg_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_valid <= 1'b0;
            reg_sel   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            reg_valid <= 1'b1;
            reg_sel   <= load_sel;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (drain) begin
            reg_valid <= 1'b0;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < N; i++) begin
            out_valid[i] = reg_valid && (reg_sel == SW'(i));
        end
    end

endmodule

// File: rtl/demux1_to_n_stream.sv
// Packet-aware 1-to-N stream demux; optional select range check via DEMUX_SEL_CHECK_EN.
module demux1_to_n_stream
    import demux_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_sel,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic          busy,
    output logic          err
);

    localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_SEL = SW'(N - 1);

    state_t        state, state_next;
    logic [SW-1:0] cur_sel, cur_sel_next;
    logic [SW-1:0] first_sel, load_sel;
    logic          in_range, sel_ok;
    logic          load, can_load, reg_valid, accept;

    assign in_range = ({1'b0, in_sel} < N_EXT);

`ifdef DEMUX_SEL_CHECK_EN
    logic err_next;

    assign sel_ok    = in_range;
    assign first_sel = in_sel;
    assign err_next  = (state == IDLE) && accept && !sel_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end
`else
    assign sel_ok    = 1'b1;
    assign first_sel = in_range ? in_sel : LAST_SEL;
    assign err       = 1'b0;
`endif

    assign in_ready = (state == DROP) ? 1'b1 : can_load;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || reg_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state   <= state_next;
            cur_sel <= cur_sel_next;
        end
    end

    always_comb begin
        state_next   = state;
        cur_sel_next = cur_sel;
        load         = 1'b0;
        load_sel     = cur_sel;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        load         = 1'b1;
                        load_sel     = first_sel;
                        cur_sel_next = first_sel;
                        if (!in_last) state_next = PASS;
                    end else if (!in_last) begin
                        state_next = DROP;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_last) state_next = IDLE;
                end
            end
            DROP: begin
                if (accept && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The held beat keeps its own channel even after cur_sel moves on.
    demux_out_reg #(
        .W (W),
        .N (N),
        .SW(SW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(in_data),
        .load_last(in_last),
        .load_sel (load_sel),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .reg_valid(reg_valid),
        .can_load (can_load)
    );

endmodule
